// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the adder_arbiter block: FSM encoding,
// default sizing and the saturation limits used by the optional clamp.
package adder_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_N       = 16;
  localparam int DEF_NUM_REQ = 4;

  // Largest positive / most negative two's-complement value of an n-bit word.
  function automatic logic [63:0] sat_max_pos(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_max_neg(input int n);
    return 64'd1 << (n - 1);
  endfunction

endpackage

// File: rtl/addsub.sv
// Shared N-bit two's-complement add/subtract unit with carry, overflow and
// true-sign flags. Subtraction is computed as A + ~B + 1.
module addsub
  import adder_arb_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         sub_i,
  output logic [N-1:0] sum_o,
  output logic         carry_o,
  output logic         overflow_o,
  output logic         negative_o
);

  logic [N-1:0] b_eff;
  logic [N-2:0] low_sum;
  logic         c_into_msb;
  logic         msb_sum;

  assign b_eff = sub_i ? ~b_i : b_i;

  // Split at the MSB so the carry into the sign bit is visible for overflow.
  assign {c_into_msb, low_sum} = {1'b0, a_i[N-2:0]} + {1'b0, b_eff[N-2:0]}
                               + {{(N-1){1'b0}}, sub_i};
  assign {carry_o, msb_sum}    = {1'b0, a_i[N-1]} + {1'b0, b_eff[N-1]}
                               + {1'b0, c_into_msb};

  assign sum_o      = {msb_sum, low_sum};
  assign overflow_o = carry_o ^ c_into_msb;
  assign negative_o = overflow_o ^ msb_sum;

endmodule

// File: rtl/rr_picker.sv
// Combinational round-robin winner select: search starts one past the last
// winner and wraps, so the most recently served requester has lowest priority.
module rr_picker
  import adder_arb_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     last_winner_i,
  output logic               gnt_valid_o,
  output logic [IDW-1:0]     gnt_idx_o
);

  logic [IDW-1:0] cand;

  // NOTE: every output gets a default before the loop, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    cand        = '0;
    // Walk farthest-to-nearest so the nearest requesting slot is written last.
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = IDW'((int'(last_winner_i) + off) % NUM_REQ);
      if (req_i[cand]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter in front of one shared add/sub unit: IDLE grants and
// captures, EXEC computes, DONE pulses res_valid. Define ADDER_ARB_SATURATE_EN
// to clamp overflowing results; otherwise the wrapped value is returned.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter  int N       = DEF_N,
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*N-1:0] op_a,
  input  logic [NUM_REQ*N-1:0] op_b,
  input  logic [NUM_REQ-1:0]   op_sub,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 res_valid,
  output logic [IDW-1:0]       res_id,
  output logic [N-1:0]         result,
  output logic                 carry,
  output logic                 overflow,
  output logic                 negative
);

  localparam logic [IDW-1:0] LAST_RST = IDW'(NUM_REQ - 1);

  state_e         state_q, state_d;
  logic [IDW-1:0] last_winner_q;
  logic [N-1:0]   a_q, b_q;
  logic           sub_q;
  logic [IDW-1:0] id_q;
  logic [IDW-1:0] res_id_q;
  logic [N-1:0]   result_q, result_d;
  logic           carry_q, overflow_q, negative_q;

  logic           gnt_valid;
  logic [IDW-1:0] gnt_idx;
  logic [N-1:0]   sel_a, sel_b;
  logic           sel_sub;
  logic           capture;
  logic [N-1:0]   sum;
  logic           sum_c, sum_v, sum_n;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_i        (req),
    .last_winner_i(last_winner_q),
    .gnt_valid_o  (gnt_valid),
    .gnt_idx_o    (gnt_idx)
  );

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_sub = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_a   = op_a[i*N +: N];
        sel_b   = op_b[i*N +: N];
        sel_sub = op_sub[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ack       = '0;
    capture   = 1'b0;
    res_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // ack is combinational from req, so hold it low while reset is applied.
        if (gnt_valid && !rst) begin
          ack[gnt_idx] = 1'b1;
          capture      = 1'b1;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_DONE;
      ST_DONE: begin
        res_valid = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q           <= '0;
      b_q           <= '0;
      sub_q         <= 1'b0;
      id_q          <= '0;
      last_winner_q <= LAST_RST;
    end else if (capture) begin
      a_q           <= sel_a;
      b_q           <= sel_b;
      sub_q         <= sel_sub;
      id_q          <= gnt_idx;
      last_winner_q <= gnt_idx;
    end
  end

  addsub #(.N(N)) u_addsub (
    .a_i       (a_q),
    .b_i       (b_q),
    .sub_i     (sub_q),
    .sum_o     (sum),
    .carry_o   (sum_c),
    .overflow_o(sum_v),
    .negative_o(sum_n)
  );

`ifdef ADDER_ARB_SATURATE_EN
  localparam logic [63:0]  SAT_POS_W = sat_max_pos(N);
  localparam logic [63:0]  SAT_NEG_W = sat_max_neg(N);
  localparam logic [N-1:0] SAT_POS   = SAT_POS_W[N-1:0];
  localparam logic [N-1:0] SAT_NEG   = SAT_NEG_W[N-1:0];

  always_comb begin
    result_d = sum;
    if (sum_v) result_d = sum_n ? SAT_NEG : SAT_POS;
  end
`else
  assign result_d = sum;
`endif

  // Result and flags update only at the end of EXEC and hold until the next op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_id_q   <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      negative_q <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      res_id_q   <= id_q;
      result_q   <= result_d;
      carry_q    <= sum_c;
      overflow_q <= sum_v;
      negative_q <= sum_n;
    end
  end

  assign res_id   = res_id_q;
  assign result   = result_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;
  assign negative = negative_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: a scoreboard queue is filled at each
// ack from an independent arithmetic model and drained at each res_valid.
module tb_adder_arbiter;

  localparam int N   = 16;
  localparam int NR  = 4;
  localparam int IDW = 2;

`ifdef ADDER_ARB_SATURATE_EN
  localparam logic [N-1:0] OVF_POS = 16'h7FFF;
  localparam logic [N-1:0] OVF_NEG = 16'h8000;
`else
  localparam logic [N-1:0] OVF_POS = 16'h8000;
  localparam logic [N-1:0] OVF_NEG = 16'h7FFF;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req;
  logic [NR*N-1:0] op_a, op_b;
  logic [NR-1:0]   op_sub;
  logic [NR-1:0]   ack;
  logic            res_valid;
  logic [IDW-1:0]  res_id;
  logic [N-1:0]    result;
  logic            carry, overflow, negative;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int           id;
    logic [N-1:0] res;
    logic         c, v, n;
    int           at;
  } exp_t;

  exp_t sbq[$];

  adder_arbiter #(.N(N), .NUM_REQ(NR)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .op_a     (op_a),
    .op_b     (op_b),
    .op_sub   (op_sub),
    .ack      (ack),
    .res_valid(res_valid),
    .res_id   (res_id),
    .result   (result),
    .carry    (carry),
    .overflow (overflow),
    .negative (negative)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: evaluate in N+2 signed bits, flag overflow when out of range.
  function automatic exp_t model(input int id, input logic [N-1:0] a,
                                 input logic [N-1:0] b, input logic sub, input int at);
    exp_t e;
    logic [N:0] u;
    logic signed [N+1:0] sa, sbv, t;
    u   = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{N{1'b0}}, sub};
    sa  = {{2{a[N-1]}}, a};
    sbv = {{2{b[N-1]}}, b};
    t   = sub ? sa - sbv : sa + sbv;
    e.id  = id;
    e.at  = at;
    e.c   = u[N];
    e.n   = t[N+1];
    e.v   = (t[N+1:N-1] != 3'b000) && (t[N+1:N-1] != 3'b111);
    e.res = t[N-1:0];
`ifdef ADDER_ARB_SATURATE_EN
    if (e.v) e.res = e.n ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`endif
    return e;
  endfunction

  // Scoreboard: push on ack, pop and compare on res_valid; reset aborts all.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sbq.delete();
    end else begin
      if (ack !== '0) begin
        checks++;
        if ($countones(ack) != 1) begin
          errors++;
          $display("FAIL ack_onehot: ack=%b, required exactly one bit set", ack);
        end
        for (int i = 0; i < NR; i++)
          if (ack[i]) sbq.push_back(model(i, op_a[i*N +: N], op_b[i*N +: N], op_sub[i], cyc));
      end
      if (res_valid === 1'b1) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: res_valid=1 with no operation outstanding");
        end else begin
          e = sbq.pop_front();
          if (res_id !== IDW'(e.id) || result !== e.res || carry !== e.c ||
              overflow !== e.v || negative !== e.n || cyc != e.at + 2) begin
            errors++;
            $display("FAIL sb_result: got id=%0d res=%h c=%b v=%b n=%b cyc=%0d, required id=%0d res=%h c=%b v=%b n=%b cyc=%0d",
                     res_id, result, carry, overflow, negative, cyc,
                     e.id, e.res, e.c, e.v, e.n, e.at + 2);
          end
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
    op_a[i*N +: N] = a;
    op_b[i*N +: N] = b;
    op_sub[i]      = s;
  endtask

  task automatic wait_ack(input int max_cyc, output int idx, output int at, output bit ok);
    ok = 1'b0; idx = -1; at = 0;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      if (ack !== '0) begin
        for (int i = NR - 1; i >= 0; i--) if (ack[i]) idx = i;
        at = cyc;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid(input int max_cyc, output int at, output bit ok);
    ok = 1'b0; at = 0;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        at = cyc;
        ok = 1'b1;
        break;
      end
    end
  endtask

  // One isolated request: raise req[i], drop it after ack, wait for the result.
  task automatic run_one(input int i, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic s, output bit ack_ok, output int idx,
                         output int lat, output bit val_ok);
    int at, vat;
    set_op(i, a, b, s);
    req    = '0;
    req[i] = 1'b1;
    wait_ack(8, idx, at, ack_ok);
    next_cycle();
    req = '0;
    wait_valid(8, vat, val_ok);
    lat = vat - at;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; op_a = '0; op_b = '0; op_sub = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ack !== '0 || res_valid !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: ack=%b res_valid=%b, required 0/0", ack, res_valid);
    end
    checks++;
    if (res_id !== '0 || result !== '0) begin
      errors++; $display("FAIL reset_data: res_id=%0d result=%h, required 0/0000", res_id, result);
    end
    checks++;
    if ({carry, overflow, negative} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: cvn=%b, required 000", {carry, overflow, negative});
    end
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_single_add();
    bit aok, vok; int idx, lat;
    run_one(0, 16'h0003, 16'h0004, 1'b0, aok, idx, lat, vok);
    checks++;
    if (!aok || idx != 0) begin
      errors++; $display("FAIL add_ack: ack_seen=%b idx=%0d, required 1/0", aok, idx);
    end
    checks++;
    if (!vok || lat != 2) begin
      errors++; $display("FAIL add_latency: valid_seen=%b latency=%0d, required 1/2", vok, lat);
    end
    checks++;
    if (result !== 16'h0007 || res_id !== 2'd0 || {carry, overflow, negative} !== 3'b000) begin
      errors++; $display("FAIL add_value: result=%h id=%0d cvn=%b, required 0007/0/000",
                         result, res_id, {carry, overflow, negative});
    end
  endtask

  task automatic test_round_robin();
    bit ok; int idx, at, prev;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < NR; i++) set_op(i, N'($urandom), N'($urandom), 1'(i % 2));
    req  = '1;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_ack(6, idx, at, ok);
      checks++;
      if (!ok || idx != (k % NR) || (k > 0 && at != prev + 3)) begin
        errors++; $display("FAIL rr_order[%0d]: ok=%b idx=%0d gap=%0d, required 1/%0d/3",
                           k, ok, idx, at - prev, k % NR);
      end
      prev = at;
    end
    next_cycle();
    req = '0;
    repeat (3) next_cycle();
  endtask

  task automatic test_sub_negative();
    bit aok, vok; int idx, lat;
    run_one(2, 16'h0002, 16'h0005, 1'b1, aok, idx, lat, vok);
    checks++;
    if (!aok || idx != 2 || !vok) begin
      errors++; $display("FAIL sub_handshake: ack_seen=%b idx=%0d valid_seen=%b, required 1/2/1", aok, idx, vok);
    end
    checks++;
    if (result !== 16'hFFFD || res_id !== 2'd2 || carry !== 1'b0 || overflow !== 1'b0 || negative !== 1'b1) begin
      errors++; $display("FAIL sub_value: result=%h id=%0d c=%b v=%b n=%b, required FFFD/2/0/0/1",
                         result, res_id, carry, overflow, negative);
    end
  endtask

  task automatic test_overflow();
    bit aok, vok; int idx, lat;
    run_one(1, 16'h7FFF, 16'h0001, 1'b0, aok, idx, lat, vok);
    checks++;
    if (!aok || !vok || result !== OVF_POS || overflow !== 1'b1 || negative !== 1'b0 || carry !== 1'b0) begin
      errors++; $display("FAIL ovf_pos: result=%h c=%b v=%b n=%b, required %h/0/1/0",
                         result, carry, overflow, negative, OVF_POS);
    end
    run_one(3, 16'h8000, 16'h0001, 1'b1, aok, idx, lat, vok);
    checks++;
    if (!aok || !vok || result !== OVF_NEG || overflow !== 1'b1 || negative !== 1'b1 || carry !== 1'b1) begin
      errors++; $display("FAIL ovf_neg: result=%h c=%b v=%b n=%b, required %h/1/1/1",
                         result, carry, overflow, negative, OVF_NEG);
    end
  endtask

  task automatic test_reset_mid();
    bit ok, saw; int idx, at;
    set_op(2, 16'h1234, 16'h1111, 1'b0);
    req = 4'b0100;
    wait_ack(8, idx, at, ok);
    checks++;
    if (!ok || idx != 2) begin
      errors++; $display("FAIL rstmid_ack: ack_seen=%b idx=%0d, required 1/2", ok, idx);
    end
    next_cycle();
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    checks++;
    if (ack !== '0 || res_valid !== 1'b0 || res_id !== '0 || result !== '0 ||
        {carry, overflow, negative} !== 3'b000) begin
      errors++; $display("FAIL rstmid_outputs: ack=%b valid=%b id=%0d result=%h cvn=%b, required all zero",
                         ack, res_valid, res_id, result, {carry, overflow, negative});
    end
    next_cycle();
    rst = 1'b0;
    saw = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (res_valid !== 1'b0) saw = 1'b1;
    end
    checks++;
    if (saw) begin
      errors++; $display("FAIL rstmid_no_valid: res_valid seen=%b after abort, required 0", saw);
    end
    next_cycle();
    req = '1;
    wait_ack(4, idx, at, ok);
    checks++;
    if (!ok || idx != 0) begin
      errors++; $display("FAIL rstmid_next_grant: ack_seen=%b idx=%0d, required 1/0", ok, idx);
    end
    next_cycle();
    req = '0;
    repeat (3) next_cycle();
  endtask

  task automatic test_drop_in_exec();
    bit ok, saw; int idx, at;
    set_op(0, 16'h0100, 16'h0023, 1'b1);
    req = 4'b0001;
    wait_ack(8, idx, at, ok);
    checks++;
    if (!ok || idx != 0) begin
      errors++; $display("FAIL drop_ack0: ack_seen=%b idx=%0d, required 1/0", ok, idx);
    end
    next_cycle();
    req = 4'b0010;
    @(negedge clk);
    checks++;
    if (ack !== '0) begin
      errors++; $display("FAIL drop_exec_ack: ack=%b during EXEC, required 0000", ack);
    end
    next_cycle();
    req = '0;
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ack[1] !== 1'b0) saw = 1'b1;
    end
    checks++;
    if (saw) begin
      errors++; $display("FAIL drop_never_acked: ack[1] seen=%b, required 0", saw);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    bit ok; int idx, at, prev;
    set_op(0, 16'h4000, 16'h0FFF, 1'b0);
    req  = 4'b0001;
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      wait_ack(6, idx, at, ok);
      checks++;
      if (!ok || idx != 0 || (k > 0 && at != prev + 3)) begin
        errors++; $display("FAIL b2b[%0d]: ok=%b idx=%0d gap=%0d, required 1/0/3", k, ok, idx, at - prev);
      end
      prev = at;
      next_cycle();
      // Operands change while the captured op is in flight.
      set_op(0, N'($urandom), N'($urandom), 1'($urandom));
    end
    req = '0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_round_robin();
    test_sub_negative();
    test_overflow();
    test_reset_mid();
    test_drop_in_exec();
    test_back_to_back();
    repeat (4) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++; $display("FAIL sb_drain: %0d results outstanding, required 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
